// File: rtl/beam_scan_pkg.sv
// Shared state encoding, default parameters and width helpers for the beam scan scheduler.
package beam_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BRST,
        FILL,
        WAIT,
        ACC,
        STEP,
        EVAL,
        DONE
    } state_t;

    localparam int N_MIC_DEF      = 4;
    localparam int N_ANGLE_DEF    = 16;
    localparam int L_DEF          = 32;
    localparam int DATA_W_DEF     = 24;
    localparam int DELTA_W_DEF    = 7;
    localparam int SETTLE_CYC_DEF = 2;

    function automatic int calc_sum_w(input int data_w, input int n_mic);
        return data_w + $clog2(n_mic);
    endfunction

    function automatic int calc_e_w(input int data_w, input int n_mic, input int l);
        return 2 * calc_sum_w(data_w, n_mic) + $clog2(l);
    endfunction

endpackage

// File: rtl/beam_energy_acc.sv
// Sums N_MIC signed samples, squares the sum and accumulates it into an unsigned energy register.
// Energy reflects a sample one cycle after en; clr takes priority over en; never stalls.
module beam_energy_acc
    import beam_scan_pkg::*;
#(
    parameter int N_MIC  = N_MIC_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int L      = L_DEF
) (
    input  logic                                     i_50M_clk,
    input  logic                                     i_rst,
    input  logic                                     clr,
    input  logic                                     en,
    input  logic [N_MIC*DATA_W-1:0]                  buf_data,
    output logic [calc_e_w(DATA_W, N_MIC, L)-1:0]    energy
);

    localparam int SUM_W = calc_sum_w(DATA_W, N_MIC);
    localparam int SQ_W  = 2 * SUM_W;
    localparam int E_W   = calc_e_w(DATA_W, N_MIC, L);

    logic signed [SUM_W-1:0] sum;
    logic signed [SQ_W-1:0]  sum_ext;
    logic        [SQ_W-1:0]  sq;

    always_comb begin
        sum = '0;
        for (int m = 0; m < N_MIC; m++) begin
            sum = sum + SUM_W'($signed(buf_data[m*DATA_W +: DATA_W]));
        end
    end

    // Squaring at double width keeps the full magnitude of the most negative sum.
    assign sum_ext = SQ_W'(sum);
    assign sq      = $unsigned(sum_ext * sum_ext);

    always_ff @(posedge i_50M_clk or posedge i_rst) begin
        if (i_rst) begin
            energy <= '0;
        end else if (clr) begin
            energy <= '0;
        end else if (en) begin
            energy <= energy + E_W'(sq);
        end
    end

endmodule

// File: rtl/beam_scan_scheduler.sv
// Delay-and-sum scan over N_ANGLE angles, L samples each, reporting the max-energy angle at o_done.
// Each sample waits SETTLE_CYC cycles after a pointer step; BEAM_SCAN_CONT_EN repeats scans until i_abort.
module beam_scan_scheduler
    import beam_scan_pkg::*;
#(
    parameter int N_MIC      = N_MIC_DEF,
    parameter int N_ANGLE    = N_ANGLE_DEF,
    parameter int L          = L_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DELTA_W    = DELTA_W_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic                                     i_50M_clk,
    input  logic                                     i_rst,
    input  logic                                     i_start,
    input  logic                                     i_abort,
    input  logic [N_MIC-1:0]                         i_init_finish,
    input  logic [N_MIC*DATA_W-1:0]                  i_buf_data,
    input  logic [N_MIC*DELTA_W-1:0]                 i_delta_tab,
    output logic                                     o_buf_rst,
    output logic                                     o_buf_start,
    output logic [N_MIC*DELTA_W-1:0]                 o_delta,
    output logic                                     o_change_pointer,
    output logic [$clog2(N_ANGLE)-1:0]               o_angle,
    output logic                                     o_busy,
    output logic                                     o_done,
    output logic [$clog2(N_ANGLE)-1:0]               o_best_angle,
    output logic [calc_e_w(DATA_W, N_MIC, L)-1:0]    o_best_energy
);

    localparam int A_W  = $clog2(N_ANGLE);
    localparam int E_W  = calc_e_w(DATA_W, N_MIC, L);
    localparam int K_W  = $clog2(L + 1);
    localparam int WC_W = $clog2(SETTLE_CYC + 2);

    state_t          state, state_nxt;
    logic [K_W-1:0]  smp_cnt;
    logic [WC_W-1:0] wait_cnt;
    logic [E_W-1:0]  energy;
    logic [A_W-1:0]  last_best_angle;
    logic [E_W-1:0]  last_best_energy;
    logic            acc_en;
    logic            acc_clr;
    logic            all_filled;
    logic            last_smp;
    logic            last_angle;

    assign all_filled = &i_init_finish;
    assign last_smp   = (smp_cnt == K_W'(L - 1));
    assign last_angle = (o_angle == A_W'(N_ANGLE - 1));

    beam_energy_acc #(
        .N_MIC  (N_MIC),
        .DATA_W (DATA_W),
        .L      (L)
    ) u_energy_acc (
        .i_50M_clk (i_50M_clk),
        .i_rst     (i_rst),
        .clr       (acc_clr),
        .en        (acc_en),
        .buf_data  (i_buf_data),
        .energy    (energy)
    );

    always_ff @(posedge i_50M_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        o_buf_rst        = 1'b0;
        o_buf_start      = 1'b0;
        o_change_pointer = 1'b0;
        o_done           = 1'b0;
        acc_en           = 1'b0;
        acc_clr          = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    acc_clr   = 1'b1;
                    state_nxt = BRST;
                end
            end
            BRST: begin
                o_buf_rst = 1'b1;
                state_nxt = FILL;
            end
            FILL: begin
                o_buf_start = 1'b1;
                if (all_filled) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt <= WC_W'(1)) begin
                    state_nxt = ACC;
                end
            end
            ACC: begin
                acc_en    = 1'b1;
                state_nxt = last_smp ? EVAL : STEP;
            end
            STEP: begin
                o_change_pointer = 1'b1;
                state_nxt        = WAIT;
            end
            EVAL: begin
                acc_clr   = 1'b1;
                state_nxt = last_angle ? DONE : BRST;
            end
            DONE: begin
                o_done = 1'b1;
`ifdef BEAM_SCAN_CONT_EN
                state_nxt = BRST;
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
        if (i_abort) begin
            state_nxt = IDLE;
            acc_en    = 1'b0;
            acc_clr   = 1'b1;
        end
    end

    // Starting a scan clears o_best_*, so the last completed result is kept aside for abort.
    always_ff @(posedge i_50M_clk or posedge i_rst) begin
        if (i_rst) begin
            o_delta          <= '0;
            o_angle          <= '0;
            o_busy           <= 1'b0;
            o_best_angle     <= '0;
            o_best_energy    <= '0;
            last_best_angle  <= '0;
            last_best_energy <= '0;
            smp_cnt          <= '0;
            wait_cnt         <= '0;
        end else if (i_abort) begin
            o_busy        <= 1'b0;
            smp_cnt       <= '0;
            o_best_angle  <= last_best_angle;
            o_best_energy <= last_best_energy;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_busy        <= 1'b1;
                        o_angle       <= '0;
                        o_best_angle  <= '0;
                        o_best_energy <= '0;
                        smp_cnt       <= '0;
                    end
                end
                BRST: o_delta <= i_delta_tab;
                FILL, STEP: wait_cnt <= WC_W'(SETTLE_CYC);
                WAIT: wait_cnt <= wait_cnt - WC_W'(1);
                ACC: smp_cnt <= smp_cnt + K_W'(1);
                EVAL: begin
                    if ((energy > o_best_energy) || (o_angle == '0)) begin
                        o_best_angle  <= o_angle;
                        o_best_energy <= energy;
                    end
                    smp_cnt <= '0;
                    if (!last_angle) begin
                        o_angle <= o_angle + A_W'(1);
                    end
                end
                DONE: begin
                    last_best_angle  <= o_best_angle;
                    last_best_energy <= o_best_energy;
`ifdef BEAM_SCAN_CONT_EN
                    o_angle <= '0;
`else
                    o_busy  <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_beam_scan_scheduler.sv
// Bench for beam_scan_scheduler: models the ring buffers and checks every scan against a behavioural argmax model.
module tb_beam_scan_scheduler;

    localparam int N_MIC      = 4;
    localparam int N_ANGLE    = 16;
    localparam int L          = 32;
    localparam int DATA_W     = 24;
    localparam int DELTA_W    = 7;
    localparam int SETTLE_CYC = 2;
    localparam int E_W        = 2 * (DATA_W + 2) + 5;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       start;
    logic                       abort;
    logic [N_MIC-1:0]           init_finish;
    logic [N_MIC*DATA_W-1:0]    buf_data;
    logic [N_MIC*DELTA_W-1:0]   delta_tab;
    logic                       buf_rst;
    logic                       buf_start;
    logic [N_MIC*DELTA_W-1:0]   delta;
    logic                       change_pointer;
    logic [3:0]                 angle;
    logic                       busy;
    logic                       done;
    logic [3:0]                 best_angle;
    logic [E_W-1:0]             best_energy;

    logic signed [DATA_W-1:0]   tbl [N_ANGLE][L][N_MIC];
    logic [4:0]                 ptr;
    int                         total = 0;
    int                         bad = 0;
    int                         ptr_steps = 0;
    int                         brst_seen = 0;
    int                         done_cnt = 0;

    always #10 clk = ~clk;

    beam_scan_scheduler dut (
        .i_50M_clk        (clk),
        .i_rst            (rst),
        .i_start          (start),
        .i_abort          (abort),
        .i_init_finish    (init_finish),
        .i_buf_data       (buf_data),
        .i_delta_tab      (delta_tab),
        .o_buf_rst        (buf_rst),
        .o_buf_start      (buf_start),
        .o_delta          (delta),
        .o_change_pointer (change_pointer),
        .o_angle          (angle),
        .o_busy           (busy),
        .o_done           (done),
        .o_best_angle     (best_angle),
        .o_best_energy    (best_energy)
    );

    function automatic logic [N_MIC*DELTA_W-1:0] tab_of(input int a);
        logic [N_MIC*DELTA_W-1:0] r;
        r = '0;
        for (int m = 0; m < N_MIC; m++) r[m*DELTA_W +: DELTA_W] = DELTA_W'(a * 3 + m * 5 + 1);
        return r;
    endfunction

    // Expected result straight from the definition: energy per angle, first strict maximum wins.
    function automatic void model(output int ba, output longint be);
        longint e;
        longint s;
        ba = 0;
        be = 0;
        for (int a = 0; a < N_ANGLE; a++) begin
            e = 0;
            for (int p = 0; p < L; p++) begin
                s = 0;
                for (int m = 0; m < N_MIC; m++) s += longint'(tbl[a][p][m]);
                e += s * s;
            end
            if (a == 0 || e > be) begin
                ba = a;
                be = e;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fill(input int mode);
        int x;
        for (int a = 0; a < N_ANGLE; a++) begin
            for (int p = 0; p < L; p++) begin
                x = int'($urandom_range(0, 1000000));
                for (int m = 0; m < N_MIC; m++) begin
                    case (mode)
                        0:       tbl[a][p][m] = DATA_W'(1);
                        1:       tbl[a][p][m] = (a == 5) ? DATA_W'(1000) : DATA_W'(0);
                        2:       tbl[a][p][m] = (m % 2 == 0) ? DATA_W'(x) : DATA_W'(-x);
                        default: tbl[a][p][m] = DATA_W'($urandom);
                    endcase
                end
            end
        end
    endtask

    // Ring-buffer stand-in: read pointer follows o_buf_rst / o_change_pointer.
    always @(posedge clk or posedge rst) begin
        if (rst) ptr <= '0;
        else if (buf_rst) ptr <= '0;
        else if (change_pointer) ptr <= ptr + 5'd1;
    end

    always_comb begin
        buf_data = '0;
        for (int m = 0; m < N_MIC; m++) buf_data[m*DATA_W +: DATA_W] = tbl[angle][ptr][m];
    end

    always_comb delta_tab = tab_of(int'(angle));

    always @(negedge clk) begin
        int     ea;
        longint ee;
        if (rst || abort) begin
            ptr_steps = 0;
            brst_seen = 0;
        end else begin
            if (change_pointer) ptr_steps++;
            if (buf_rst) begin
                if (brst_seen != 0) chk("steps_per_angle", 64'(ptr_steps), 64'(L - 1));
                chk("brst_angle", 64'(angle), 64'(brst_seen));
                ptr_steps = 0;
                brst_seen++;
            end
            if (buf_start) chk("delta_reg", 64'(delta), 64'(tab_of(int'(angle))));
            if (done) begin
                model(ea, ee);
                chk("steps_last_angle", 64'(ptr_steps), 64'(L - 1));
                chk("brst_count", 64'(brst_seen), 64'(N_ANGLE));
                chk("best_angle", 64'(best_angle), 64'(ea));
                chk("best_energy", 64'(best_energy), 64'(ee));
                done_cnt++;
                ptr_steps = 0;
                brst_seen = 0;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_buf_rst"}, 64'(buf_rst), 0);
        chk({tag, "_buf_start"}, 64'(buf_start), 0);
        chk({tag, "_delta"}, 64'(delta), 0);
        chk({tag, "_chg_ptr"}, 64'(change_pointer), 0);
        chk({tag, "_angle"}, 64'(angle), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_best_angle"}, 64'(best_angle), 0);
        chk({tag, "_best_energy"}, 64'(best_energy), 0);
    endtask

    task automatic finish_scan(input int d0);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk("scan_done", 64'(done), 1);
`ifdef BEAM_SCAN_CONT_EN
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (buf_rst !== 1'b1 && n < 20);
        chk("cont_restart_rst", 64'(buf_rst), 1);
        chk("cont_restart_angle", 64'(angle), 0);
        chk("cont_busy", 64'(busy), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
`else
        @(negedge clk);
        chk("busy_after_done", 64'(busy), 0);
        chk("done_one_cycle", 64'(done), 0);
        repeat (3) @(negedge clk);
        chk("idle_after_done", 64'(buf_rst), 0);
`endif
        chk("done_pulses", 64'(done_cnt - d0), 1);
    endtask

    task automatic run_scan(input int mode);
        int d0;
        fill(mode);
        d0 = done_cnt;
        pulse_start();
        finish_scan(d0);
    endtask

    initial begin
        int n;
        int d0;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        init_finish = '1;
        fill(0);
        repeat (3) @(negedge clk);
        chk_idle("in_reset");
        rst = 1'b0;
        @(negedge clk);
        chk_idle("after_reset");

        run_scan(0);
        chk("const_best_angle", 64'(best_angle), 0);
        chk("const_best_energy", 64'(best_energy), 512);

        // Reset while stuck in FILL
        fill(1);
        init_finish = '0;
        pulse_start();
        n = 0;
        while (buf_start !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fill_entered", 64'(buf_start), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_idle("mid_fill_reset");
        d0 = done_cnt;
        repeat (10) @(negedge clk);
        chk("mid_fill_no_done", 64'(done_cnt - d0), 0);
        chk("mid_fill_stays_idle", 64'(buf_start), 0);
        init_finish = '1;

        run_scan(2);
        chk("cancel_best_angle", 64'(best_angle), 0);
        chk("cancel_best_energy", 64'(best_energy), 0);

        // Partial fill holds the block in FILL; completing it releases the first sample
        fill(3);
        init_finish = 4'b0111;
        d0 = done_cnt;
        pulse_start();
        repeat (20) @(negedge clk);
        chk("hold_fill", 64'(buf_start), 1);
        chk("hold_busy", 64'(busy), 1);
        init_finish = 4'b1111;
        @(negedge clk);
        chk("fill_release", 64'(buf_start), 0);
        n = 1;
        while (change_pointer !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("first_step_latency", 64'(n), 64'(SETTLE_CYC + 2));
        finish_scan(d0);

        run_scan(3);
        run_scan(1);
        chk("peak_best_angle", 64'(best_angle), 5);
        chk("peak_best_energy", 64'(best_energy), 512000000);

        // Abort during a pointer step of angle 7
        fill(3);
        pulse_start();
        n = 0;
        while (!(angle == 4'd7 && change_pointer === 1'b1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_angle7_step", 64'({angle, change_pointer}), 64'({4'd7, 1'b1}));
        d0 = done_cnt;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 0);
        chk("abort_buf_start", 64'(buf_start), 0);
        chk("abort_chg_ptr", 64'(change_pointer), 0);
        chk("abort_best_angle", 64'(best_angle), 5);
        chk("abort_best_energy", 64'(best_energy), 512000000);
        repeat (20) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt - d0), 0);
        chk("abort_stays_idle", 64'({buf_rst, buf_start, busy}), 0);

        // Start and abort together in IDLE
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", 64'(busy), 0);
        chk("start_abort_rst", 64'(buf_rst), 0);
        @(negedge clk);
        chk("start_abort_idle", 64'({buf_rst, buf_start, busy}), 0);

        run_scan(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1400000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
